// File: rtl/pipe_front_regs_if.sv
// Hazard-control and pipeline-register bundle between the fetch/decode front end and its surroundings.
// The master drives controls and ID-stage inputs; the slave (pipe_front_regs) owns the register outputs.
interface pipe_front_regs_if;
   logic        pc_ctrl;
   logic        if_id_ctrl;
   logic        id_ex_ctrl;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr_if;
   logic [7:0]  ctrl_id;
   logic [4:0]  rw_id;

   logic [31:0] pc;
   logic [31:0] instr_id;
   logic [31:0] pc4_id;
   logic        valid_id;
   logic [7:0]  ctrl_ex;
   logic [4:0]  rt_ex;
   logic [4:0]  rw_ex;
   logic [31:0] pc4_ex;
   logic        valid_ex;
   logic [15:0] stall_cnt;
   logic        stall_timeout;

   modport master (
      output pc_ctrl, if_id_ctrl, id_ex_ctrl, branch_taken, branch_target,
             instr_if, ctrl_id, rw_id,
      input  pc, instr_id, pc4_id, valid_id, ctrl_ex, rt_ex, rw_ex, pc4_ex,
             valid_ex, stall_cnt, stall_timeout
   );

   modport slave (
      input  pc_ctrl, if_id_ctrl, id_ex_ctrl, branch_taken, branch_target,
             instr_if, ctrl_id, rw_id,
      output pc, instr_id, pc4_id, valid_id, ctrl_ex, rt_ex, rw_ex, pc4_ex,
             valid_ex, stall_cnt, stall_timeout
   );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers with hazard-unit hold/bubble/flush control
// and stall statistics (total stall cycles plus a sticky long-stall flag).
module pipe_front_regs #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned STALL_LIMIT = 8
) (
   input logic             clk,
   input logic             rst,
   pipe_front_regs_if.slave bus
);
   localparam int unsigned       CW    = $clog2(STALL_LIMIT + 1);
   localparam logic [CW-1:0]     LIMIT = CW'(STALL_LIMIT);

   logic [31:0]   pc_plus4;
   logic [CW-1:0] run_cnt;
   logic          flush;

   assign pc_plus4 = bus.pc + 32'd4;
   // A branch seen while the PC is held has unresolved operands and is dropped.
   assign flush    = bus.branch_taken && !bus.pc_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.pc <= RESET_PC;
      end else if (!bus.pc_ctrl) begin
         bus.pc <= bus.branch_taken ? bus.branch_target : pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.instr_id <= '0;
         bus.pc4_id   <= '0;
         bus.valid_id <= 1'b0;
      end else if (!bus.if_id_ctrl) begin
         if (flush) begin
            bus.instr_id <= '0;
            bus.valid_id <= 1'b0;
         end else begin
            bus.instr_id <= bus.instr_if;
            bus.pc4_id   <= pc_plus4;
            bus.valid_id <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ctrl_ex  <= '0;
         bus.rt_ex    <= '0;
         bus.rw_ex    <= '0;
         bus.pc4_ex   <= '0;
         bus.valid_ex <= 1'b0;
      end else if (bus.id_ex_ctrl) begin
         bus.ctrl_ex  <= '0;
         bus.rt_ex    <= '0;
         bus.rw_ex    <= '0;
         bus.valid_ex <= 1'b0;
      end else begin
         // An empty IF/ID slot must not leak RegWr/MemWr or a destination downstream.
         bus.ctrl_ex  <= bus.valid_id ? bus.ctrl_id : '0;
         bus.rw_ex    <= bus.valid_id ? bus.rw_id : '0;
         bus.rt_ex    <= bus.instr_id[20:16];
         bus.pc4_ex   <= bus.pc4_id;
         bus.valid_ex <= bus.valid_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.stall_cnt     <= '0;
         bus.stall_timeout <= 1'b0;
         run_cnt           <= '0;
      end else if (bus.pc_ctrl) begin
         if (bus.stall_cnt != '1) begin
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
         end
         if (run_cnt != LIMIT) begin
            run_cnt <= run_cnt + 1'b1;
         end
         if (run_cnt >= LIMIT - 1'b1) begin
            bus.stall_timeout <= 1'b1;
         end
      end else begin
         run_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed scenarios with literal expectations, then
// randomized hazard/branch traffic compared every cycle against a register-level model.
module tb_pipe_front_regs;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          LIMIT  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   pipe_front_regs_if bus();

   pipe_front_regs #(.RESET_PC(RST_PC), .STALL_LIMIT(LIMIT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: pipeline slots as plain values, stall statistics as integers.
   logic [31:0] m_pc, m_instr_id, m_pc4_id, m_pc4_ex;
   logic        m_valid_id, m_valid_ex, m_timeout;
   logic [7:0]  m_ctrl_ex;
   logic [4:0]  m_rt_ex, m_rw_ex;
   int          m_stalls, m_run;
   bit          m_ready = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = RST_PC; m_instr_id = 0; m_pc4_id = 0; m_valid_id = 0;
         m_ctrl_ex = 0; m_rt_ex = 0; m_rw_ex = 0; m_pc4_ex = 0; m_valid_ex = 0;
         m_stalls = 0; m_run = 0; m_timeout = 0;
         m_ready = 1'b1;
      end else if (m_ready) begin
         // ID/EX takes what IF/ID held before this edge
         if (bus.id_ex_ctrl) begin
            m_ctrl_ex = 0; m_rt_ex = 0; m_rw_ex = 0; m_valid_ex = 0;
         end else begin
            m_ctrl_ex  = m_valid_id ? bus.ctrl_id : 8'h00;
            m_rw_ex    = m_valid_id ? bus.rw_id : 5'h00;
            m_rt_ex    = m_instr_id[20:16];
            m_pc4_ex   = m_pc4_id;
            m_valid_ex = m_valid_id;
         end
         if (!bus.if_id_ctrl) begin
            if (bus.branch_taken && !bus.pc_ctrl) begin
               m_instr_id = 0; m_valid_id = 0;
            end else begin
               m_instr_id = bus.instr_if; m_pc4_id = m_pc + 32'd4; m_valid_id = 1;
            end
         end
         if (!bus.pc_ctrl) m_pc = bus.branch_taken ? bus.branch_target : m_pc + 32'd4;
         if (bus.pc_ctrl) begin
            if (m_stalls < 65535) m_stalls++;
            if (m_run < LIMIT) m_run++;
            if (m_run == LIMIT) m_timeout = 1;
         end else begin
            m_run = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         check("pc", bus.pc, m_pc);
         check("instr_id", bus.instr_id, m_instr_id);
         check("pc4_id", bus.pc4_id, m_pc4_id);
         check("valid_id", 32'(bus.valid_id), 32'(m_valid_id));
         check("ctrl_ex", 32'(bus.ctrl_ex), 32'(m_ctrl_ex));
         check("rt_ex", 32'(bus.rt_ex), 32'(m_rt_ex));
         check("rw_ex", 32'(bus.rw_ex), 32'(m_rw_ex));
         check("pc4_ex", bus.pc4_ex, m_pc4_ex);
         check("valid_ex", 32'(bus.valid_ex), 32'(m_valid_ex));
         check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stalls));
         check("stall_timeout", 32'(bus.stall_timeout), 32'(m_timeout));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input logic p, input logic f, input logic e, input logic b, input logic [31:0] t);
      bus.pc_ctrl = p; bus.if_id_ctrl = f; bus.id_ex_ctrl = e;
      bus.branch_taken = b; bus.branch_target = t;
   endtask

   task automatic feed(input logic [31:0] i, input logic [7:0] c, input logic [4:0] r);
      bus.instr_if = i; bus.ctrl_id = c; bus.rw_id = r;
   endtask

   localparam logic [31:0] I0 = 32'h00A5_1234, I1 = 32'h0013_5678, I2 = 32'h1234_0000;
   localparam logic [31:0] I3 = 32'hDEAD_BEEF, I4 = 32'h0F0F_0F0F, I5 = 32'h5555_AAAA;

   int rem = 0;
   bit smode = 0;

   initial begin
      ctl(0, 0, 0, 0, 0);
      feed(0, 0, 0);
      rst = 1'b1;
      cyc();
      check("rst_pc", bus.pc, RST_PC);
      check("rst_instr_id", bus.instr_id, 0);
      check("rst_valid_id", 32'(bus.valid_id), 0);
      check("rst_valid_ex", 32'(bus.valid_ex), 0);
      check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
      rst = 1'b0;

      feed(I0, 8'hFF, 5'h1F);
      cyc();
      check("c1_pc", bus.pc, 32'h4);
      check("c1_instr_id", bus.instr_id, I0);
      check("c1_ctrl_ex_empty", 32'(bus.ctrl_ex), 0);
      check("c1_rw_ex_empty", 32'(bus.rw_ex), 0);

      feed(I1, 8'h81, 5'h03);
      cyc();
      check("c2_pc", bus.pc, 32'h8);
      check("c2_ctrl_ex", 32'(bus.ctrl_ex), 32'h81);
      check("c2_rw_ex", 32'(bus.rw_ex), 32'h03);
      check("c2_rt_ex", 32'(bus.rt_ex), 32'h05);
      check("c2_valid_ex", 32'(bus.valid_ex), 1);

      ctl(1, 1, 1, 0, 0);
      feed(I2, 8'h42, 5'h07);
      cyc();
      check("stall_pc", bus.pc, 32'h8);
      check("stall_instr_id", bus.instr_id, I1);
      check("stall_ctrl_ex", 32'(bus.ctrl_ex), 0);
      check("stall_valid_ex", 32'(bus.valid_ex), 0);
      check("stall_cnt1", 32'(bus.stall_cnt), 1);

      ctl(0, 0, 0, 0, 0);
      cyc();
      check("resume_pc", bus.pc, 32'hC);
      check("resume_ctrl_ex", 32'(bus.ctrl_ex), 32'h42);
      check("resume_rt_ex", 32'(bus.rt_ex), 32'h13);

      ctl(0, 0, 0, 1, 32'h100);
      feed(I3, 8'h11, 5'h02);
      cyc();
      check("br_pc", bus.pc, 32'h100);
      check("br_instr_id", bus.instr_id, 0);
      check("br_valid_id", 32'(bus.valid_id), 0);
      check("br_pc4_id_kept", bus.pc4_id, 32'hC);

      ctl(0, 0, 0, 0, 0);
      feed(I4, 8'hFF, 5'h1F);
      cyc();
      check("flush_ctrl_ex", 32'(bus.ctrl_ex), 0);
      check("flush_rw_ex", 32'(bus.rw_ex), 0);
      check("flush_pc", bus.pc, 32'h104);

      ctl(1, 1, 1, 1, 32'h200);
      feed(I5, 8'h33, 5'h04);
      cyc();
      check("brstall_pc", bus.pc, 32'h104);
      check("brstall_instr_id", bus.instr_id, I4);
      ctl(0, 0, 0, 1, 32'h200);
      cyc();
      check("brlate_pc", bus.pc, 32'h200);

      // seven stalls, a gap, then one more must not reach the limit
      ctl(1, 0, 0, 0, 0);
      repeat (7) cyc();
      ctl(0, 0, 0, 0, 0);
      cyc();
      ctl(1, 0, 0, 0, 0);
      cyc();
      check("gap_timeout", 32'(bus.stall_timeout), 0);
      check("gap_stall_cnt", 32'(bus.stall_cnt), 10);

      ctl(0, 0, 0, 0, 0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      ctl(1, 0, 0, 0, 0);
      repeat (7) cyc();
      check("lim7_timeout", 32'(bus.stall_timeout), 0);
      cyc();
      check("lim8_timeout", 32'(bus.stall_timeout), 1);
      check("lim8_stall_cnt", 32'(bus.stall_cnt), 8);
      ctl(0, 0, 0, 0, 0);
      cyc();
      check("sticky_timeout", 32'(bus.stall_timeout), 1);

      ctl(1, 1, 1, 0, 0);
      repeat (2) cyc();
      ctl(1, 1, 1, 1, 32'h300);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("midrst_pc", bus.pc, RST_PC);
      check("midrst_stall_cnt", 32'(bus.stall_cnt), 0);
      check("midrst_timeout", 32'(bus.stall_timeout), 0);
      check("midrst_valid_id", 32'(bus.valid_id), 0);

      repeat (3000) begin
         if (rem == 0) begin
            rem   = $urandom_range(1, 12);
            smode = ($urandom_range(0, 2) == 0);
         end
         rem--;
         bus.pc_ctrl       = smode;
         bus.if_id_ctrl    = smode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         bus.id_ex_ctrl    = smode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         bus.branch_taken  = ($urandom_range(0, 5) == 0);
         bus.branch_target = $urandom & 32'hFFFF_FFFC;
         bus.instr_if      = $urandom;
         bus.ctrl_id       = 8'($urandom);
         bus.rw_id         = 5'($urandom);
         rst               = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0;
      ctl(0, 0, 0, 0, 0);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter STALL_LIMIT, 8, consecutive-stall cycle count that raises stall_timeout.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pc_ctrl  in  1  from hazard unit; 1 = hold PC.
REQ-006 if_id_ctrl  in  1  from hazard unit; 1 = hold IF/ID register.
REQ-007 id_ex_ctrl  in  1  from hazard unit; 1 = insert bubble into ID/EX.
REQ-008 branch_taken  in  1  ID-stage branch resolved taken.
REQ-009 branch_target  in  32  ID-stage branch target address.
REQ-010 instr_if  in  32  instruction fetched at pc.
REQ-011 ctrl_id  in  8  decoded ID-stage control bits (RegWr, MemtoReg, MemWr, Branch, ALUSrc, RegDst, 2 ALUop bits).
REQ-012 rw_id  in  5  ID-stage destination register after RegDst select.
REQ-013 pc  out  32  fetch address.
REQ-014 instr_id, pc4_id  out  32 each  IF/ID instruction and PC+4.
REQ-015 valid_id  out  1  IF/ID holds a real instruction.
REQ-016 ctrl_ex  out  8; rt_ex, rw_ex  out  5 each; pc4_ex  out  32; valid_ex  out  1  ID/EX contents.
REQ-017 stall_cnt  out  16  total stall cycles since reset.
REQ-018 stall_timeout  out  1  sticky flag: hazard unit stalled STALL_LIMIT or more consecutive cycles.

Function
REQ-019 PC update priority SHALL be: rst > pc_ctrl (hold) > branch_taken (pc <= branch_target) > pc <= pc+4, addition modulo 2^32.
REQ-020 When pc_ctrl=1 and branch_taken=1 in the same cycle, branch_taken SHALL be ignored that cycle (operands not yet valid).
REQ-021 IF/ID priority SHALL be: rst > if_id_ctrl (hold all IF/ID outputs) > branch_taken with pc_ctrl=0 (flush: instr_id=0, valid_id=0, pc4_id unchanged) > capture instr_id<=instr_if, pc4_id<=pc+4, valid_id<=1.
REQ-022 ID/EX SHALL, when id_ex_ctrl=1, load a bubble: ctrl_ex=0, rt_ex=0, rw_ex=0, valid_ex=0, pc4_ex unchanged.
REQ-023 ID/EX SHALL otherwise capture ctrl_ex<=ctrl_id, rt_ex<=instr_id[20:16], rw_ex<=rw_id, pc4_ex<=pc4_id, valid_ex<=valid_id.
REQ-024 When valid_id=0 and id_ex_ctrl=0, ID/EX SHALL load ctrl_ex=0 and rw_ex=0 regardless of ctrl_id/rw_id.
REQ-025 A bubble or flushed slot SHALL never carry RegWr=1 or MemWr=1, so no false hazard or store is generated downstream.
REQ-026 Latency: instruction at pc appears on instr_id 1 cycle later and on ctrl_ex/rw_ex 2 cycles later absent stalls.
REQ-027 stall_cnt SHALL increment by 1 each cycle pc_ctrl=1, saturating at 16'hFFFF.
REQ-028 An internal consecutive-stall counter SHALL increment each pc_ctrl=1 cycle (saturating at STALL_LIMIT) and clear on any pc_ctrl=0 cycle.
REQ-029 stall_timeout SHALL set on the edge where the consecutive counter reaches STALL_LIMIT and remain 1 until rst.
REQ-030 Inputs pc_ctrl, if_id_ctrl, id_ex_ctrl SHALL be sampled only at the rising edge; no output changes between edges.

Reset
REQ-031 On rst=1 at a rising edge: pc=RESET_PC; instr_id, pc4_id, valid_id, ctrl_ex, rt_ex, rw_ex, pc4_ex, valid_ex, stall_cnt, stall_timeout and consecutive counter all 0.
REQ-032 rst SHALL override every other input in the same cycle, including mid-stall and mid-branch.

Verification
REQ-033 Reset then 3 cycles no stall, instr_if=I0,I1,I2 -> pc=0,4,8,C; instr_id=I0 at cycle 2; ctrl_ex of I0 at cycle 3; valid_ex=1.
REQ-034 pc_ctrl=if_id_ctrl=id_ex_ctrl=1 for 1 cycle at pc=8 -> pc stays 8, instr_id held, ctrl_ex=0, rw_ex=0, valid_ex=0, stall_cnt=1; next cycle resumes pc=C.
REQ-035 branch_taken=1, branch_target=0x100, no stall -> pc=0x100 next cycle, instr_id=0, valid_id=0; following cycle ctrl_ex=0.
REQ-036 branch_taken=1 with pc_ctrl=if_id_ctrl=id_ex_ctrl=1 -> pc held, instr_id held, branch ignored; branch_taken next cycle with no stall -> redirect to branch_target.
REQ-037 pc_ctrl=1 for 8 consecutive cycles (STALL_LIMIT=8) -> stall_timeout=1 after 8th edge, stays 1 after pc_ctrl drops; stall_cnt=8.
REQ-038 rst asserted during a 3-cycle stall -> all outputs at reset values next edge; stall_cnt=0, pc=RESET_PC.
